// File: rtl/crc8_apb_ctrl.sv
// -----------------------------------------------------------------------------
// crc8_apb_ctrl
//
// APB-programmable front end for an external byte-wide CRC-8 engine. Software
// pushes bytes into a small FIFO through the DATA register. A controller FSM
// hands the bytes to the engine one at a time: a one-cycle start pulse, then a
// fixed 8-cycle wait for the engine to finish. The CTRL register requests an
// engine clear. The FSM runs the clear only after every queued byte has been
// issued. The CRC register returns the engine value once everything has settled.
//
// Register map (paddr_i[3:2]):
//   0 DATA   write-only  pwdata_i[7:0] pushed into the FIFO
//   1 CRC    read-only   {24'h0, crc_i}; stalls until FIFO empty, FSM idle,
//                        and no clear pending
//   2 CTRL   write-only  pwdata_i[0]=1 requests an engine clear
//   3 STATUS read-only   {25'h0, count[3:0], empty, full, busy}
//
// APB handshake: a transfer is in its access phase while psel_i && penable_i.
// It completes on the rising edge that ends a cycle in which pready_o=1.
// pready_o, pslverr_o and prdata_o are all 0 outside a completing access.
// Illegal accesses are a read of DATA or CTRL, or a write of CRC or STATUS.
// They complete at once with pslverr_o=1 and have no side effects.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   psel_i .. pwdata_i    APB requester inputs
//   prdata_o, pready_o,
//   pslverr_o             APB completer outputs
//   crc_din_o             byte for the engine (valid only while crc_valid_o)
//   crc_valid_o           one-cycle start pulse to the engine
//   crc_rd_o              one-cycle clear pulse to the engine
//   crc_i                 current engine CRC value
//   dbg_state_o           current controller state, for observation
// -----------------------------------------------------------------------------
module crc8_apb_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [3:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [7:0]  crc_din_o,
    output logic        crc_valid_o,
    output logic        crc_rd_o,
    input  logic [7:0]  crc_i,
    output logic [2:0]  dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CLEAR   = 3'd3,
        S_CLRWAIT = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wait_cnt;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_clr_pend;
    logic            r_crc_valid;
    logic            r_crc_rd;
    logic [7:0]      r_crc_din;

    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_access;
    logic            w_push;
    logic            w_pop;
    logic            w_clr_set;
    logic            w_ready;
    logic            w_err;
    logic [31:0]     w_rdata;
    logic [31:0]     w_status;
    logic            w_wait_done;

    // Upper data bits and the byte-lane address bits carry no meaning here.
    logic            w_unused;
    assign w_unused = &{1'b0, pwdata_i[31:8], paddr_i[1:0]};

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != S_IDLE) || !w_empty || r_clr_pend;
    assign w_status    = {25'h0, 4'(r_count), w_empty, w_full, w_busy};
    assign w_access    = psel_i && penable_i;
    assign w_wait_done = (r_wait_cnt == 4'd7);
    assign w_pop       = (r_state == S_ISSUE);

    // APB decode. Everything here is gated by reset so that the bus outputs
    // read as zero while rst_i is high, independent of the requester.
    always_comb begin
        w_ready   = 1'b0;
        w_err     = 1'b0;
        w_rdata   = 32'h0;
        w_push    = 1'b0;
        w_clr_set = 1'b0;
        if (w_access && !rst_i) begin
            unique case (paddr_i[3:2])
                2'd0: begin
                    if (pwrite_i) begin
                        // Full uses registered state: a pop in this same cycle
                        // does not make room for this write.
                        w_ready = !w_full && !r_clr_pend;
                        w_push  = w_ready;
                    end else begin
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                    end
                end
                2'd1: begin
                    if (!pwrite_i) begin
                        w_ready = w_empty && (r_state == S_IDLE) && !r_clr_pend;
                        if (w_ready) w_rdata = {24'h0, crc_i};
                    end else begin
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                    end
                end
                2'd2: begin
                    if (pwrite_i) begin
                        w_ready   = 1'b1;
                        w_clr_set = pwdata_i[0];
                    end else begin
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                    end
                end
                default: begin
                    if (!pwrite_i) begin
                        w_ready = 1'b1;
                        w_rdata = w_status;
                    end else begin
                        w_ready = 1'b1;
                        w_err   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign pready_o  = w_ready;
    assign pslverr_o = w_err;
    assign prdata_o  = w_rdata;

    // Controller FSM: next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                // Queued bytes are issued before any pending clear.
                if (!w_empty)        w_next = S_ISSUE;
                else if (r_clr_pend) w_next = S_CLEAR;
            end
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (w_wait_done) w_next = S_IDLE;
            S_CLEAR:   w_next = S_CLRWAIT;
            S_CLRWAIT: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 r_wait_cnt <= 4'd0;
        else if (r_state != S_WAIT) r_wait_cnt <= 4'd0;
        else if (w_wait_done)      r_wait_cnt <= 4'd0;
        else                       r_wait_cnt <= r_wait_cnt + 4'd1;
    end

    // FIFO storage needs no reset; the pointers and count define its contents.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= pwdata_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new clear request that arrives while one is being issued is kept
    // rather than lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   r_clr_pend <= 1'b0;
        else if (w_clr_set)          r_clr_pend <= 1'b1;
        else if (r_state == S_CLEAR) r_clr_pend <= 1'b0;
    end

    // Engine outputs are registered from the next state, so they are high for
    // exactly the cycle the FSM spends in ISSUE or CLEAR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_crc_valid <= 1'b0;
            r_crc_rd    <= 1'b0;
            r_crc_din   <= 8'h0;
        end else begin
            r_crc_valid <= (w_next == S_ISSUE);
            r_crc_rd    <= (w_next == S_CLEAR);
            r_crc_din   <= (w_next == S_ISSUE) ? r_mem[r_rd_ptr] : 8'h0;
        end
    end

    assign crc_valid_o = r_crc_valid;
    assign crc_rd_o    = r_crc_rd;
    assign crc_din_o   = r_crc_din;
    assign dbg_state_o = r_state;

endmodule
